// File: rtl/program_loader.sv
// program_loader: boot loader streaming words into instruction memory then big-endian bytes into data memory.
// Optional LOADER_CHECKSUM_EN adds a mod-2^32 checksum output of every accepted word.
module program_loader #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  instr_count,
  input  logic [8:0]  data_count,
  input  logic        src_valid,
  input  logic [31:0] src_word,
  output logic        src_ready,
  output logic [31:0] instruction_store,
  output logic [7:0]  instr_addr,
  output logic        instruction_load,
  output logic [7:0]  data_store,
  output logic [9:0]  data_addr,
  output logic        data_load,
  output logic        ready,
  output logic        load_error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);
  typedef enum logic [2:0] {IDLE, INSTR, DATA, DONE, ERR} state_t;
  state_t      state;
  logic [8:0]  icnt, dcnt, widx, dw;
  logic [9:0]  daddr;
  logic [31:0] word_buf;
  logic [2:0]  pend;
  logic        hs, too_big;
  // once the final data word is buffered, no further words are taken
  always_comb begin
    src_ready = state == INSTR || (state == DATA && pend <= 3'd1 && dw != dcnt);
    hs = src_valid & src_ready;
    too_big = 32'(instr_count) > IMEM_DEPTH || 32'({data_count, 2'b00}) > DMEM_BYTES;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      icnt <= '0;
      dcnt <= '0;
      widx <= '0;
      dw <= '0;
      daddr <= '0;
      word_buf <= '0;
      pend <= '0;
      instruction_store <= '0;
      instr_addr <= '0;
      instruction_load <= 1'b0;
      data_store <= '0;
      data_addr <= '0;
      data_load <= 1'b0;
      ready <= 1'b0;
      load_error <= 1'b0;
    end else begin
      instruction_load <= 1'b0;
      data_load <= 1'b0;
      case (state)
        IDLE: if (start) begin
          icnt <= instr_count;
          dcnt <= data_count;
          widx <= '0;
          dw <= '0;
          daddr <= '0;
          pend <= '0;
          load_error <= too_big;
          state <= too_big ? ERR : instr_count != 0 ? INSTR : data_count != 0 ? DATA : DONE;
        end
        INSTR: if (hs) begin
          instruction_store <= src_word;
          instr_addr <= widx[7:0];
          instruction_load <= 1'b1;
          widx <= widx + 9'd1;
          if (widx + 9'd1 == icnt) state <= dcnt != 0 ? DATA : DONE;
        end
        DATA: begin
          if (pend != 0) begin
            data_store <= word_buf[31:24];
            data_addr <= daddr;
            data_load <= 1'b1;
            daddr <= daddr + 10'd1;
            word_buf <= word_buf << 8;
            pend <= pend - 3'd1;
          end
          // a word taken on the last-byte edge refills the buffer with no gap
          if (hs) begin
            word_buf <= src_word;
            pend <= 3'd4;
            dw <= dw + 9'd1;
          end else if (pend == 3'd1 && dw == dcnt) state <= DONE;
        end
        DONE: ready <= 1'b1;
        ERR: load_error <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) checksum <= '0;
    else if (hs) checksum <= checksum + src_word;
  end
`endif
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;
  logic        clk = 0, rst = 1, start = 0, src_valid = 0;
  logic [8:0]  instr_count = 0, data_count = 0;
  logic [31:0] src_word = 0;
  logic        src_ready, instruction_load, data_load, ready, load_error;
  logic [31:0] instruction_store;
  logic [7:0]  instr_addr, data_store;
  logic [9:0]  data_addr;
  int checks = 0, errors = 0, pulses;
  logic [7:0]  exp_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [31:0] words3 [3] = '{32'h20100032, 32'h2011ff9c, 32'h10000005};
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  always #5 clk = ~clk;
  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .instr_count(instr_count), .data_count(data_count),
    .src_valid(src_valid), .src_word(src_word), .src_ready(src_ready),
    .instruction_store(instruction_store), .instr_addr(instr_addr), .instruction_load(instruction_load),
    .data_store(data_store), .data_addr(data_addr), .data_load(data_load),
    .ready(ready), .load_error(load_error)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_rst;
    rst = 1;
    tick;
    rst = 0;
  endtask
  task automatic do_start(input logic [8:0] ic, input logic [8:0] dc);
    instr_count = ic;
    data_count = dc;
    start = 1;
    tick;
    start = 0;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_srdy"}, 32'(src_ready), 0);
    chk({tag, "_iload"}, 32'(instruction_load), 0);
    chk({tag, "_istore"}, instruction_store, 0);
    chk({tag, "_iaddr"}, 32'(instr_addr), 0);
    chk({tag, "_dload"}, 32'(data_load), 0);
    chk({tag, "_dstore"}, 32'(data_store), 0);
    chk({tag, "_daddr"}, 32'(data_addr), 0);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_err"}, 32'(load_error), 0);
  endtask
  initial begin
    tick;
    tick;
    rst = 0;
    tick;
    all_zero("reset");
    src_valid = 1;
    tick;
    tick;
    chk("idle_iload", 32'(instruction_load), 0);
    chk("idle_dload", 32'(data_load), 0);
    chk("idle_srdy", 32'(src_ready), 0);
    src_valid = 0;
    do_start(3, 0);
    chk("instr_srdy", 32'(src_ready), 1);
    src_valid = 1;
    for (int i = 0; i < 3; i++) begin
      src_word = words3[i];
      tick;
      chk("i3_load", 32'(instruction_load), 1);
      chk("i3_addr", 32'(instr_addr), i);
      chk("i3_word", instruction_store, words3[i]);
      chk("i3_ready_lo", 32'(ready), 0);
    end
    src_valid = 0;
    tick;
    chk("i3_ready", 32'(ready), 1);
    chk("i3_load_off", 32'(instruction_load), 0);
    chk("done_srdy", 32'(src_ready), 0);
    pulse_rst;
    do_start(1, 2);
    src_valid = 1;
    src_word = 32'h00000013;
    tick;
    chk("mix_iload", 32'(instruction_load), 1);
    chk("mix_data_srdy", 32'(src_ready), 1);
    src_word = 32'h11223344;
    tick;
    chk("mix_hs_srdy", 32'(src_ready), 0);
    chk("mix_hs_dload", 32'(data_load), 0);
    src_word = 32'hAABBCCDD;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("mix_dload", 32'(data_load), 1);
      chk("mix_byte", 32'(data_store), 32'(exp_bytes[i]));
      chk("mix_daddr", 32'(data_addr), i);
      if (i < 6) chk("mix_srdy", 32'(src_ready), (i == 2) ? 1 : 0);
      chk("mix_ready_lo", 32'(ready), 0);
    end
    src_valid = 0;
    tick;
    chk("mix_ready", 32'(ready), 1);
    chk("mix_dload_off", 32'(data_load), 0);
    pulse_rst;
    do_start(4, 0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      src_valid = ~k[0];
      src_word = 32'h100 + 32'(k / 2);
      tick;
      if (k[0] == 0) begin
        pulses++;
        chk("tog_load", 32'(instruction_load), 1);
        chk("tog_addr", 32'(instr_addr), k / 2);
        chk("tog_word", instruction_store, 32'h100 + 32'(k / 2));
      end else chk("tog_noload", 32'(instruction_load), 0);
    end
    src_valid = 0;
    tick;
    chk("tog_ready", 32'(ready), 1);
    chk("tog_pulses", 32'(pulses), 4);
    pulse_rst;
    do_start(257, 0);
    chk("err_flag", 32'(load_error), 1);
    chk("err_srdy", 32'(src_ready), 0);
    src_valid = 1;
    tick;
    tick;
    chk("err_iload", 32'(instruction_load), 0);
    chk("err_dload", 32'(data_load), 0);
    chk("err_ready", 32'(ready), 0);
    chk("err_sticky", 32'(load_error), 1);
    src_valid = 0;
    pulse_rst;
    chk("err_cleared", 32'(load_error), 0);
    do_start(0, 257);
    chk("derr_flag", 32'(load_error), 1);
    pulse_rst;
    do_start(256, 256);
    chk("full_ok", 32'(load_error), 0);
    chk("full_srdy", 32'(src_ready), 1);
    pulse_rst;
    do_start(5, 0);
    src_valid = 1;
    src_word = 32'hDEAD0000;
    tick;
    src_word = 32'hDEAD0001;
    tick;
    chk("abort_pre_addr", 32'(instr_addr), 1);
    rst = 1;
    tick;
    rst = 0;
    all_zero("abort");
    src_valid = 0;
    do_start(1, 0);
    src_valid = 1;
    src_word = 32'hCAFEF00D;
    tick;
    chk("reload_load", 32'(instruction_load), 1);
    chk("reload_addr", 32'(instr_addr), 0);
    chk("reload_word", instruction_store, 32'hCAFEF00D);
    src_valid = 0;
    tick;
    chk("reload_ready", 32'(ready), 1);
`ifdef LOADER_CHECKSUM_EN
    pulse_rst;
    do_start(2, 0);
    src_valid = 1;
    src_word = 32'hFFFFFFFF;
    tick;
    src_word = 32'h00000002;
    tick;
    src_valid = 0;
    tick;
    chk("cs_ready", 32'(ready), 1);
    chk("cs_value", checksum, 32'h00000001);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
